// File: rtl/pulses_param_pkg.sv
// Shared frame layout, reset defaults and receiver state encoding for the pulse generator parameters.
package pulses_param_pkg;

  localparam logic [7:0]  HEADER      = 8'hA5;
  localparam int unsigned PAYLOAD_LEN = 18;
  localparam int unsigned FRAME_BITS  = PAYLOAD_LEN * 8;

  localparam int unsigned OFF_PER      = 0;
  localparam int unsigned OFF_P1WID    = 4;
  localparam int unsigned OFF_DEL      = 6;
  localparam int unsigned OFF_P2WID    = 8;
  localparam int unsigned OFF_NUT_W    = 10;
  localparam int unsigned OFF_NUT_D    = 11;
  localparam int unsigned OFF_CP       = 13;
  localparam int unsigned OFF_P_BL     = 14;
  localparam int unsigned OFF_P_BL_OFF = 15;
  localparam int unsigned OFF_BL       = 17;

  typedef enum logic [1:0] {HUNT, PAYLOAD, CSUM, COMMIT} state_e;

  typedef struct packed {
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic        bl;
  } param_t;

  localparam param_t PARAM_DEFAULT = '{
    per: 32'd65536, p1wid: 16'd30, del: 16'd200, p2wid: 16'd30, nut_w: 8'd50,
    nut_d: 16'd300, cp: 8'd3, p_bl: 8'd50, p_bl_off: 16'd100, bl: 1'b1
  };

  // First byte of the frame sits in the MSBs of the assembled shadow vector.
  function automatic int unsigned byte_msb(input int unsigned off);
    return FRAME_BITS - 1 - 8 * off;
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte watchdog: clears on activity, counts idle cycles while enabled, flags the terminal count.
module byte_timeout #(
  parameter int unsigned LIMIT = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en_i && !clr_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Activity in the terminal cycle wins over the timeout.
  assign expire_c = en_i && !clr_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/param_frame_rx.sv
// Assembles a parameter frame from the PC byte stream and commits it atomically with a load strobe.
// Optional trailing XOR checksum byte enabled by defining PARAM_CSUM_EN.
module param_frame_rx
  import pulses_param_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter int unsigned STROBE_LEN  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [7:0]  nut_w,
  output logic [15:0] nut_d,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_off,
  output logic        bl,
  output logic        rxd,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam int unsigned IDX_W = $clog2(PAYLOAD_LEN);
  localparam int unsigned STB_W = $clog2(STROBE_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRAME_BITS-1:0] shadow_q;
  param_t                live_q;
  logic [STB_W-1:0]      stb_cnt_q;
  logic                  rxd_q, frame_err_q;
  logic [7:0]            err_cnt_q;
  logic                  shift_c, commit_c, err_c, tmo_en_c, tmo_c;
`ifdef PARAM_CSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  byte_timeout #(.LIMIT(TIMEOUT_CYC)) u_byte_timeout (
    .clk      (clk),
    .reset    (reset),
    .en_i     (tmo_en_c),
    .clr_i    (rx_valid),
    .expire_c (tmo_c)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_c  = 1'b0;
    commit_c = 1'b0;
    err_c    = 1'b0;
    tmo_en_c = 1'b0;
`ifdef PARAM_CSUM_EN
    xor_d    = xor_q;
`endif
    case (state_q)
      // COMMIT lasts one cycle and otherwise listens like HUNT.
      HUNT, COMMIT: begin
        commit_c = (state_q == COMMIT);
        state_d  = HUNT;
        if (rx_valid && rx_data == HEADER) begin
          state_d = PAYLOAD;
          idx_d   = '0;
`ifdef PARAM_CSUM_EN
          xor_d   = '0;
`endif
        end
      end
      PAYLOAD: begin
        tmo_en_c = 1'b1;
        if (rx_valid) begin
          shift_c = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
`ifdef PARAM_CSUM_EN
          xor_d   = xor_q ^ rx_data;
          if (idx_q == LAST_IDX) state_d = CSUM;
`else
          if (idx_q == LAST_IDX) state_d = COMMIT;
`endif
        end else if (tmo_c) begin
          err_c   = 1'b1;
          state_d = HUNT;
        end
      end
`ifdef PARAM_CSUM_EN
      CSUM: begin
        tmo_en_c = 1'b1;
        if (rx_valid) begin
          if (rx_data == xor_q) begin
            state_d = COMMIT;
          end else begin
            err_c   = 1'b1;
            state_d = HUNT;
          end
        end else if (tmo_c) begin
          err_c   = 1'b1;
          state_d = HUNT;
        end
      end
`endif
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HUNT;
      idx_q   <= '0;
`ifdef PARAM_CSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef PARAM_CSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  // Shadow is fully rewritten by every complete frame, so it needs no reset.
  always_ff @(posedge clk) begin
    if (shift_c) shadow_q <= {shadow_q[FRAME_BITS-9:0], rx_data};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      live_q      <= PARAM_DEFAULT;
      rxd_q       <= 1'b0;
      stb_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      frame_err_q <= err_c;
      if (err_c && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      if (commit_c) begin
        live_q <= '{
          per:      shadow_q[byte_msb(OFF_PER)      -: 32],
          p1wid:    shadow_q[byte_msb(OFF_P1WID)    -: 16],
          del:      shadow_q[byte_msb(OFF_DEL)      -: 16],
          p2wid:    shadow_q[byte_msb(OFF_P2WID)    -: 16],
          nut_w:    shadow_q[byte_msb(OFF_NUT_W)    -: 8],
          nut_d:    shadow_q[byte_msb(OFF_NUT_D)    -: 16],
          cp:       shadow_q[byte_msb(OFF_CP)       -: 8],
          p_bl:     shadow_q[byte_msb(OFF_P_BL)     -: 8],
          p_bl_off: shadow_q[byte_msb(OFF_P_BL_OFF) -: 16],
          bl:       shadow_q[byte_msb(OFF_BL) - 7]
        };
        rxd_q     <= 1'b1;
        stb_cnt_q <= STB_W'(STROBE_LEN - 1);
      end else if (stb_cnt_q != '0) begin
        stb_cnt_q <= stb_cnt_q - STB_W'(1);
      end else begin
        rxd_q <= 1'b0;
      end
    end
  end

  logic unused_bl_bits;
  assign unused_bl_bits = ^shadow_q[byte_msb(OFF_BL) -: 7];

  assign per       = live_q.per;
  assign p1wid     = live_q.p1wid;
  assign del       = live_q.del;
  assign p2wid     = live_q.p2wid;
  assign nut_w     = live_q.nut_w;
  assign nut_d     = live_q.nut_d;
  assign cp        = live_q.cp;
  assign p_bl      = live_q.p_bl;
  assign p_bl_off  = live_q.p_bl_off;
  assign bl        = live_q.bl;
  assign rxd       = rxd_q;
  assign frame_err = frame_err_q;
  assign err_count = err_cnt_q;

endmodule
